// File: rtl/mem_seq_pkg.sv
// Shared types for the memory address sequencer:
// FSM states, source codes and counter sizing.
package mem_seq_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam logic SRC_PC = 1'b0;
  localparam logic SRC_IR = 1'b1;

  // Request record {src, we, addr}: two flag bits above the address.
  localparam int REQ_META_W = 2;

  function automatic int req_w(input int addr_w);
    return addr_w + REQ_META_W;
  endfunction

  // Wait counter counts WAIT_CYC-1 down to 0; never narrower than 1 bit.
  function automatic int cnt_w(input int wait_cyc);
    int w;
    w = $clog2(wait_cyc + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_req_slot.sv
// One-entry pending request register with load/clear and drop detect.
// Ports: clr_i frees the entry, fetch/data candidates, valid_o/rec_o, drop_o.
module mem_req_slot
  import mem_seq_pkg::*;
#(
  parameter int W = req_w(5)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         fetch_v_i,
  input  logic [W-1:0] fetch_rec_i,
  input  logic         data_v_i,
  input  logic [W-1:0] data_rec_i,
  output logic         valid_o,
  output logic [W-1:0] rec_o,
  output logic         drop_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] rec_q, rec_d;
  logic         free;

  // Entry freed this cycle may be refilled the same cycle.
  // Fetch wins the slot; a competing data request is dropped.
  always_comb begin
    free    = !valid_q || clr_i;
    valid_d = valid_q && !clr_i;
    rec_d   = rec_q;
    drop_o  = 1'b0;
    if (fetch_v_i) begin
      if (free) begin
        valid_d = 1'b1;
        rec_d   = fetch_rec_i;
      end else begin
        drop_o = 1'b1;
      end
    end
    if (data_v_i) begin
      if (fetch_v_i || !free) begin
        drop_o = 1'b1;
      end else begin
        valid_d = 1'b1;
        rec_d   = data_rec_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      rec_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rec_q   <= rec_d;
    end
  end

  assign valid_o = valid_q;
  assign rec_o   = rec_q;

endmodule

// File: rtl/mem_addr_seq.sv
// Sequences PC fetches and IR operand accesses onto one registered
// address bus with timed rd/wr strobes, done pulses and a pending slot.
// Ports: clk/rst, fetch_req/adpc, data_req/data_we/adir in;
// admem, mem_rd, mem_wr, src, busy, fetch_done, data_done, ovr out.
module mem_addr_seq
  import mem_seq_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] adpc,
  input  logic [ADDR_W-1:0] adir,
  output logic [ADDR_W-1:0] admem,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              src,
  output logic              busy,
  output logic              fetch_done,
  output logic              data_done,
  output logic              ovr
);

  localparam int CW = cnt_w(WAIT_CYC);
  localparam int RW = req_w(ADDR_W);

  if (WAIT_CYC < 1 || WAIT_CYC > 15) begin : g_bad_wait
    $error("mem_addr_seq: WAIT_CYC must be in 1..15");
  end

  typedef struct packed {
    logic              src;
    logic              we;
    logic [ADDR_W-1:0] addr;
  } req_t;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] admem_q, admem_d;
  logic              src_q, src_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              fd_q, fd_d;
  logic              dd_q, dd_d;
  logic              ovr_q, ovr_d;

  req_t    f_rec, d_rec, slot_rec, sel_rec;
  logic [RW-1:0] slot_bits;
  logic    slot_v, slot_drop;
  logic    idle, sel_v, clr;
  logic    f_lose, d_lose;

  assign f_rec    = '{src: SRC_PC, we: 1'b0, addr: adpc};
  assign d_rec    = '{src: SRC_IR, we: data_we, addr: adir};
  assign slot_rec = req_t'(slot_bits);

  // Selection priority: pending slot, then fetch, then data.
  // Anything not started this cycle competes for the slot.
  always_comb begin
    idle    = (state_q == IDLE);
    sel_v   = idle && (slot_v || fetch_req || data_req);
    clr     = idle && slot_v;
    f_lose  = fetch_req && !(idle && !slot_v);
    d_lose  = data_req && !(idle && !slot_v && !fetch_req);
    if (slot_v) begin
      sel_rec = slot_rec;
    end else if (fetch_req) begin
      sel_rec = f_rec;
    end else begin
      sel_rec = d_rec;
    end
  end

  mem_req_slot #(
    .W(RW)
  ) u_slot (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (clr),
    .fetch_v_i   (f_lose),
    .fetch_rec_i (f_rec),
    .data_v_i    (d_lose),
    .data_rec_i  (d_rec),
    .valid_o     (slot_v),
    .rec_o       (slot_bits),
    .drop_o      (slot_drop)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    admem_d = admem_q;
    src_d   = src_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    fd_d    = 1'b0;
    dd_d    = 1'b0;
    ovr_d   = ovr_q | slot_drop;
    case (state_q)
      IDLE: begin
        if (sel_v) begin
          state_d = ACCESS;
          cnt_d   = CW'(WAIT_CYC - 1);
          admem_d = sel_rec.addr;
          src_d   = sel_rec.src;
          rd_d    = !sel_rec.we;
          wr_d    = sel_rec.we;
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          fd_d    = (src_q == SRC_PC);
          dd_d    = (src_q == SRC_IR);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      admem_q <= '0;
      src_q   <= SRC_PC;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      fd_q    <= 1'b0;
      dd_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      admem_q <= admem_d;
      src_q   <= src_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      fd_q    <= fd_d;
      dd_q    <= dd_d;
      ovr_q   <= ovr_d;
    end
  end

  assign admem      = admem_q;
  assign src        = src_q;
  assign mem_rd     = rd_q;
  assign mem_wr     = wr_q;
  assign busy       = (state_q == ACCESS);
  assign fetch_done = fd_q;
  assign data_done  = dd_q;
  assign ovr        = ovr_q;

endmodule

// File: tb/tb_mem_addr_seq.sv
// Randomized and directed bench for mem_addr_seq (ADDR_W=5, WAIT_CYC=2)
// against a transaction-level queue model.
module tb_mem_addr_seq;

  localparam int AW = 5;
  localparam int WC = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fetch_req = 1'b0;
  logic          data_req = 1'b0;
  logic          data_we = 1'b0;
  logic [AW-1:0] adpc = '0;
  logic [AW-1:0] adir = '0;
  logic [AW-1:0] admem;
  logic          mem_rd, mem_wr, src, busy;
  logic          fetch_done, data_done, ovr;

  always #5 clk = ~clk;

  mem_addr_seq #(
    .ADDR_W   (AW),
    .WAIT_CYC (WC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_req  (fetch_req),
    .data_req   (data_req),
    .data_we    (data_we),
    .adpc       (adpc),
    .adir       (adir),
    .admem      (admem),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .src        (src),
    .busy       (busy),
    .fetch_done (fetch_done),
    .data_done  (data_done),
    .ovr        (ovr)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit       src;
    bit       we;
    bit [4:0] addr;
  } rec_t;

  // Model: strobe cycles left of the current access, last record, queue.
  int       left = 0;
  bit [4:0] m_addr = '0;
  bit       m_src = 1'b0, m_we = 1'b0;
  bit       m_fd = 1'b0, m_dd = 1'b0, m_ovr = 1'b0;
  rec_t     pend[$];

  task automatic model_step(input bit r, input bit f, input bit d,
                            input bit we, input bit [4:0] pc,
                            input bit [4:0] ir);
    rec_t arr[$];
    rec_t cand[$];
    rec_t c;
    m_fd = 1'b0;
    m_dd = 1'b0;
    if (r) begin
      left = 0; m_addr = '0; m_src = 1'b0; m_we = 1'b0;
      m_ovr = 1'b0; pend.delete();
      return;
    end
    if (f) arr.push_back('{src: 1'b0, we: 1'b0, addr: pc});
    if (d) arr.push_back('{src: 1'b1, we: we, addr: ir});
    if (left == 0) begin
      foreach (pend[i]) cand.push_back(pend[i]);
      pend.delete();
      foreach (arr[i]) cand.push_back(arr[i]);
      arr.delete();
      if (cand.size() > 0) begin
        c = cand.pop_front();
        m_addr = c.addr; m_src = c.src; m_we = c.we;
        left = WC;
      end
      arr = cand;
    end else begin
      left--;
      if (left == 0) begin
        if (m_src) m_dd = 1'b1;
        else m_fd = 1'b1;
      end
    end
    foreach (arr[i]) begin
      if (pend.size() == 0) pend.push_back(arr[i]);
      else m_ovr = 1'b1;
    end
  endtask

  function automatic logic [11:0] m_outs();
    bit act;
    act = (left > 0);
    return {m_addr, m_src, act && !m_we, act && m_we, act,
            m_fd, m_dd, m_ovr};
  endfunction

  wire [11:0] outs = {admem, src, mem_rd, mem_wr, busy,
                      fetch_done, data_done, ovr};

  // Called at a negedge: drive, take one posedge, compare at next negedge.
  task automatic tick(input bit r, input bit f, input bit d,
                      input bit we, input bit [4:0] pc,
                      input bit [4:0] ir, input string tag);
    rst = r; fetch_req = f; data_req = d;
    data_we = we; adpc = pc; adir = ir;
    @(posedge clk);
    model_step(r, f, d, we, pc, ir);
    @(negedge clk);
    chk(tag, 32'(outs), 32'(m_outs()));
    chk("excl", 32'(mem_rd & mem_wr), 32'd0);
    rst = 1'b0; fetch_req = 1'b0; data_req = 1'b0;
  endtask

  task automatic nop();
    tick(0, 0, 0, 0, 5'h0, 5'h0, "nop");
  endtask

  bit rr, rf, rd, rw;

  initial begin
    @(negedge clk);
    tick(1, 0, 0, 0, 5'h0, 5'h0, "rst");
    for (int i = 0; i < 5; i++) begin
      nop();
      chk("idle_outs", 32'(outs), 32'd0);
    end

    tick(0, 1, 0, 0, 5'h0A, 5'h0, "fetch");
    chk("f_addr", 32'(admem), 32'h0A);
    chk("f_rd1", 32'(mem_rd), 32'd1);
    nop();
    chk("f_rd2", 32'(mem_rd), 32'd1);
    nop();
    chk("f_done", 32'(fetch_done), 32'd1);
    chk("f_rd_off", 32'(mem_rd), 32'd0);
    nop();

    tick(0, 1, 1, 1, 5'h03, 5'h1F, "simul");
    chk("s_addr", 32'(admem), 32'h03);
    nop();
    nop();
    chk("s_fdone", 32'(fetch_done), 32'd1);
    nop();
    chk("s_wr1", 32'({admem, mem_wr}), 32'({5'h1F, 1'b1}));
    nop();
    chk("s_wr2", 32'(mem_wr), 32'd1);
    nop();
    chk("s_ddone", 32'({data_done, mem_wr}), 32'b10);

    tick(0, 1, 0, 0, 5'h08, 5'h0, "ov_f");
    tick(0, 0, 1, 0, 5'h0, 5'h04, "ov_d");
    tick(0, 1, 0, 0, 5'h06, 5'h0, "ov_f2");
    chk("ov_flag", 32'(ovr), 32'd1);
    nop();
    chk("ov_next", 32'({admem, src, mem_rd}), 32'({5'h04, 1'b1, 1'b1}));
    nop();
    nop();
    chk("ov_ddone", 32'(data_done), 32'd1);
    nop();
    chk("ov_no06", 32'(busy), 32'd0);
    chk("ov_sticky", 32'(ovr), 32'd1);

    tick(1, 0, 0, 0, 5'h0, 5'h0, "rst2");
    tick(0, 1, 0, 0, 5'h11, 5'h0, "rm_f");
    tick(0, 0, 1, 0, 5'h0, 5'h15, "rm_d");
    tick(1, 0, 0, 0, 5'h0, 5'h0, "rm_rst");
    chk("rm_outs", 32'(outs), 32'd0);
    for (int i = 0; i < 3; i++) begin
      nop();
      chk("rm_quiet", 32'({busy, fetch_done, data_done}), 32'd0);
    end

    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 0, 0, 5'(i), 5'h0, "b2b");
      chk("b2b_addr", 32'({admem, mem_rd}), 32'({5'(i), 1'b1}));
      nop();
      nop();
      chk("b2b_done", 32'(fetch_done), 32'd1);
    end
    chk("b2b_ovr", 32'(ovr), 32'd0);

    for (int i = 0; i < 400; i++) begin
      rr = ($urandom_range(0, 63) == 0);
      rf = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 2) == 0);
      rw = 1'($urandom);
      tick(rr, rf, rd, rw, 5'($urandom), 5'($urandom), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
